lif_spike_rate_monitor: RTL and testbench

//  Downstream consumer of the LIF neuron spike output. Counts spikes per window
//  of W integration steps and reports a saturating count with a 1-cycle valid

---
 rtl/lif_spike_rate_monitor.sv | 183 ++++++++++++++++++
 tb/tb_lif_spike_rate_monitor.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lif_spike_rate_monitor.sv
// Windowed spike-rate monitor for a LIF neuron: counts spikes over W steps and pulses the result.
// Define LIF_MON_ISI_EN to add per-window minimum inter-spike-interval tracking on isi_min_o.
module lif_spike_rate_monitor #(
  parameter int WIN_BITS = 8,
  parameter int CNT_BITS = 8,
  parameter int ISI_BITS = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                step_i,
  input  logic                spike_i,
  input  logic [WIN_BITS-1:0] win_len_i,
  input  logic                cont_i,
  input  logic                clear_i,
  output logic                busy_o,
  output logic [CNT_BITS-1:0] count_out_o,
  output logic                count_ovf_o,
  output logic                count_vld_o,
  output logic [ISI_BITS-1:0] isi_min_o
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] COUNT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

  logic [1:0]          state_q, state_d;
  logic [WIN_BITS:0]   win_q, win_d;
  logic [WIN_BITS:0]   stepCnt_q, stepCnt_d;
  logic [CNT_BITS-1:0] acc_q, acc_d;
  logic                ovf_q, ovf_d;
  logic [CNT_BITS-1:0] countOut_q, countOut_d;
  logic                countOvf_q, countOvf_d;
  logic                countVld_q, countVld_d;

  logic                accept;
  logic                firstStep;
  logic                lastStep;
  logic [WIN_BITS:0]   winStart;
  logic [WIN_BITS:0]   curWin;
  logic [WIN_BITS:0]   baseCnt;
  logic [WIN_BITS:0]   nextCnt;
  logic [CNT_BITS-1:0] baseAcc;
  logic                baseOvf;
  logic [CNT_BITS-1:0] nextAcc;
  logic                nextOvf;

  // A zero window length encodes the full 2**WIN_BITS steps, hence the extra bit.
  assign winStart  = (win_len_i == '0) ? {1'b1, {WIN_BITS{1'b0}}} : {1'b0, win_len_i};

  assign accept    = step_i & ~clear_i & (state_q != DONE);
  assign firstStep = accept & (state_q == IDLE);
  assign curWin    = firstStep ? winStart : win_q;
  assign baseCnt   = firstStep ? '0 : stepCnt_q;
  assign nextCnt   = baseCnt + 1'b1;
  assign lastStep  = accept & (nextCnt == curWin);

  assign baseAcc   = firstStep ? '0 : acc_q;
  assign baseOvf   = firstStep ? 1'b0 : ovf_q;
  assign nextAcc   = (spike_i && (baseAcc != CNT_MAX)) ? baseAcc + 1'b1 : baseAcc;
  assign nextOvf   = baseOvf | (spike_i & (baseAcc == CNT_MAX));

  // In continuous mode the last step drops back to IDLE so the very next step opens a new window.
  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    stepCnt_d  = stepCnt_q;
    acc_d      = acc_q;
    ovf_d      = ovf_q;
    countOut_d = countOut_q;
    countOvf_d = countOvf_q;
    countVld_d = 1'b0;
    if (clear_i) begin
      state_d   = IDLE;
      stepCnt_d = '0;
      acc_d     = '0;
      ovf_d     = 1'b0;
    end else if (accept) begin
      win_d     = curWin;
      stepCnt_d = nextCnt;
      acc_d     = nextAcc;
      ovf_d     = nextOvf;
      state_d   = COUNT;
      if (lastStep) begin
        countOut_d = nextAcc;
        countOvf_d = nextOvf;
        countVld_d = 1'b1;
        state_d    = cont_i ? IDLE : DONE;
        stepCnt_d  = '0;
        acc_d      = '0;
        ovf_d      = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      win_q      <= '0;
      stepCnt_q  <= '0;
      acc_q      <= '0;
      ovf_q      <= 1'b0;
      countOut_q <= '0;
      countOvf_q <= 1'b0;
      countVld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      stepCnt_q  <= stepCnt_d;
      acc_q      <= acc_d;
      ovf_q      <= ovf_d;
      countOut_q <= countOut_d;
      countOvf_q <= countOvf_d;
      countVld_q <= countVld_d;
    end
  end

  assign busy_o      = (state_q == COUNT);
  assign count_out_o = countOut_q;
  assign count_ovf_o = countOvf_q;
  assign count_vld_o = countVld_q;

`ifdef LIF_MON_ISI_EN
  localparam logic [ISI_BITS-1:0] ISI_MAX = '1;

  logic [ISI_BITS-1:0] isiCnt_q, isiCnt_d;
  logic [ISI_BITS-1:0] isiRun_q, isiRun_d;
  logic [ISI_BITS-1:0] isiMin_q, isiMin_d;
  logic                seen_q, seen_d;
  logic [ISI_BITS-1:0] isiGap;
  logic [ISI_BITS-1:0] baseRun;
  logic                baseSeen;
  logic [ISI_BITS-1:0] runMin;

  // isiCnt holds steps elapsed since the last spike, so the gap to a spike on this step is isiCnt+1.
  assign isiGap   = (isiCnt_q == ISI_MAX) ? ISI_MAX : isiCnt_q + 1'b1;
  assign baseSeen = firstStep ? 1'b0 : seen_q;
  assign baseRun  = firstStep ? ISI_MAX : isiRun_q;
  assign runMin   = (spike_i && baseSeen && (isiGap < baseRun)) ? isiGap : baseRun;

  always_comb begin
    isiCnt_d = isiCnt_q;
    isiRun_d = isiRun_q;
    isiMin_d = isiMin_q;
    seen_d   = seen_q;
    if (clear_i) begin
      isiCnt_d = '0;
      isiRun_d = ISI_MAX;
      seen_d   = 1'b0;
    end else if (accept) begin
      isiCnt_d = spike_i ? '0 : isiGap;
      isiRun_d = runMin;
      seen_d   = baseSeen | spike_i;
      if (lastStep) begin
        isiMin_d = runMin;
        isiCnt_d = '0;
        isiRun_d = ISI_MAX;
        seen_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      isiCnt_q <= '0;
      isiRun_q <= ISI_MAX;
      isiMin_q <= ISI_MAX;
      seen_q   <= 1'b0;
    end else begin
      isiCnt_q <= isiCnt_d;
      isiRun_q <= isiRun_d;
      isiMin_q <= isiMin_d;
      seen_q   <= seen_d;
    end
  end

  assign isi_min_o = isiMin_q;
`else
  assign isi_min_o = '1;
`endif

endmodule

// File: tb/tb_lif_spike_rate_monitor.sv
// Scoreboard bench for lif_spike_rate_monitor: a window-level model predicts each result pulse.
// Honours LIF_MON_ISI_EN for the expected isi_min value.
module tb_lif_spike_rate_monitor;

  localparam int WB   = 3;
  localparam int CB   = 2;
  localparam int IB   = 8;
  localparam int CMAX = (1 << CB) - 1;
  localparam int IMAX = (1 << IB) - 1;

  logic          clk = 1'b0;
  logic          rstN = 1'b0;
  logic          step = 1'b0;
  logic          spike = 1'b0;
  logic [WB-1:0] winLen = '0;
  logic          cont = 1'b0;
  logic          clear = 1'b0;
  logic          busy;
  logic [CB-1:0] countOut;
  logic          countOvf;
  logic          countVld;
  logic [IB-1:0] isiMin;

  always #5 clk = ~clk;

  lif_spike_rate_monitor #(
    .WIN_BITS(WB),
    .CNT_BITS(CB),
    .ISI_BITS(IB)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rstN),
    .step_i     (step),
    .spike_i    (spike),
    .win_len_i  (winLen),
    .cont_i     (cont),
    .clear_i    (clear),
    .busy_o     (busy),
    .count_out_o(countOut),
    .count_ovf_o(countOvf),
    .count_vld_o(countVld),
    .isi_min_o  (isiMin)
  );

  typedef struct {
    int cnt;
    int ovf;
    int isi;
    int cyc;
  } expT;

  expT expQ[$];
  int  nCompared = 0;
  int  nMismatched = 0;
  int  cycleCnt = 0;

  // Window-level reference: remembers which step indices spiked and summarises at window end.
  bit  mInWin = 1'b0;
  bit  mDone = 1'b0;
  int  mWin = 0;
  int  mSteps = 0;
  int  spikeIdx[$];
  int  expBusy = 0;
  int  expCount = 0;
  int  expOvf = 0;
  int  expIsi = IMAX;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycleCnt);
    end
  endtask

  function automatic void finishWindow();
    expT e;
    int  n;
    int  best;
    n    = spikeIdx.size();
    best = IMAX;
`ifdef LIF_MON_ISI_EN
    for (int i = 1; i < n; i++) begin
      int d;
      d = spikeIdx[i] - spikeIdx[i-1];
      if (d > IMAX) d = IMAX;
      if (d < best) best = d;
    end
`endif
    e.cnt = (n > CMAX) ? CMAX : n;
    e.ovf = (n > CMAX) ? 1 : 0;
    e.isi = best;
    e.cyc = cycleCnt + 1;
    expQ.push_back(e);
    expCount = e.cnt;
    expOvf   = e.ovf;
    expIsi   = e.isi;
  endfunction

  function automatic void modelStep(input bit stp, input bit spk, input int wl, input bit cnt,
                                    input bit clr);
    if (clr) begin
      mInWin = 1'b0;
      mDone  = 1'b0;
      spikeIdx.delete();
    end else if (stp && !mDone) begin
      if (!mInWin) begin
        mWin   = (wl == 0) ? (1 << WB) : wl;
        mSteps = 0;
        spikeIdx.delete();
        mInWin = 1'b1;
      end
      mSteps++;
      if (spk) spikeIdx.push_back(mSteps);
      if (mSteps == mWin) begin
        finishWindow();
        mInWin = 1'b0;
        mDone  = !cnt;
      end
    end
    expBusy = mInWin ? 1 : 0;
  endfunction

  // One clock of stimulus; first confirms the steady outputs produced by the previous clock.
  task automatic applyStimulus(input bit stp, input bit spk, input int wl, input bit cnt,
                               input bit clr);
    @(negedge clk);
    checkOutput("busy", int'(busy), expBusy);
    checkOutput("count_out_held", int'(countOut), expCount);
    checkOutput("count_ovf_held", int'(countOvf), expOvf);
    checkOutput("isi_min_held", int'(isiMin), expIsi);
    step   = stp;
    spike  = spk;
    winLen = WB'(wl);
    cont   = cnt;
    clear  = clr;
    modelStep(stp, spk, wl, cnt, clr);
  endtask

  task automatic applyReset();
    @(negedge clk);
    rstN  = 1'b0;
    step  = 1'b0;
    spike = 1'b0;
    clear = 1'b0;
    cont  = 1'b0;
    @(negedge clk);
    rstN     = 1'b1;
    mInWin   = 1'b0;
    mDone    = 1'b0;
    spikeIdx.delete();
    expBusy  = 0;
    expCount = 0;
    expOvf   = 0;
    expIsi   = IMAX;
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_count_out", int'(countOut), 0);
    checkOutput("reset_count_ovf", int'(countOvf), 0);
    checkOutput("reset_count_vld", int'(countVld), 0);
    checkOutput("reset_isi_min", int'(isiMin), IMAX);
  endtask

  // Result monitor: every valid pulse must match the oldest prediction, on the predicted cycle.
  always @(negedge clk) begin
    if (rstN && countVld === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("vld_unexpected", 1, 0);
      end else begin
        expT e;
        e = expQ.pop_front();
        checkOutput("vld_count_out", int'(countOut), e.cnt);
        checkOutput("vld_count_ovf", int'(countOvf), e.ovf);
        checkOutput("vld_isi_min", int'(isiMin), e.isi);
        checkOutput("vld_latency_cycle", cycleCnt, e.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    applyReset();

    // Single-shot window of 4 with spikes 1,0,1,1, then steps ignored while DONE.
    applyStimulus(1, 1, 4, 0, 0);
    applyStimulus(1, 0, 4, 0, 0);
    applyStimulus(1, 1, 4, 0, 0);
    applyStimulus(1, 1, 4, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 4, 0, 0);
    applyStimulus(0, 0, 4, 0, 1);

    // Back-to-back windows of 3 with every step spiking.
    for (int i = 0; i < 6; i++) applyStimulus(1, 1, 3, 1, 0);
    applyStimulus(0, 0, 3, 0, 1);

    // win_len=0 means 8 steps; 8 spikes saturate a 2-bit count.
    for (int i = 0; i < 8; i++) applyStimulus(1, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1);

    // Clear on the 2nd step aborts the window; a fresh quiet window follows.
    applyStimulus(1, 1, 4, 0, 0);
    applyStimulus(1, 1, 4, 0, 1);
    applyStimulus(0, 0, 4, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, 4, 0, 0);
    applyStimulus(0, 0, 4, 0, 1);

    // Idle-cycle spikes are ignored and a mid-window win_len change is not picked up.
    applyStimulus(1, 0, 2, 0, 0);
    applyStimulus(0, 1, 5, 0, 0);
    applyStimulus(0, 1, 5, 0, 0);
    applyStimulus(1, 0, 5, 0, 0);
    applyStimulus(0, 0, 5, 0, 1);

    // Minimum gap: spikes on steps 2,5,7 of 7; then a window of 3 with a lone spike.
    for (int i = 1; i <= 7; i++) applyStimulus(1, (i == 2 || i == 5 || i == 7), 7, 1, 0);
    applyStimulus(1, 0, 3, 1, 0);
    applyStimulus(1, 1, 3, 1, 0);
    applyStimulus(1, 0, 3, 1, 0);

    // W=1 windows complete on every step and never show busy.
    for (int i = 0; i < 3; i++) applyStimulus(1, i[0], 1, 1, 0);

    // Reset in the middle of a window.
    applyStimulus(1, 1, 5, 0, 0);
    applyStimulus(1, 1, 5, 0, 0);
    applyStimulus(0, 0, 5, 0, 0);
    applyReset();

    for (int i = 0; i < 400; i++) begin
      bit rs;
      bit rp;
      bit rc;
      bit rcl;
      int rw;
      rs  = ($urandom_range(0, 9) < 7);
      rp  = ($urandom_range(0, 1) == 1);
      rc  = ($urandom_range(0, 9) < 7);
      rcl = ($urandom_range(0, 99) < 5);
      rw  = $urandom_range(0, (1 << WB) - 1);
      applyStimulus(rs, rp, rw, rc, rcl);
    end

    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0);
    checkOutput("pending_vld", expQ.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
